// File: rtl/register_file_mp_if.sv
// rtl/register_file_mp_if.sv - read, write and scoreboard signals of the multi-port register file
interface register_file_mp_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic [NREAD*ADDR_W-1:0] ra;
  logic [NREAD*WIDTH-1:0]  rd;
  logic [NREAD-1:0]        rd_busy;
  logic                    we0;
  logic [ADDR_W-1:0]       wa0;
  logic [WIDTH-1:0]        wd0;
  logic                    we1;
  logic [ADDR_W-1:0]       wa1;
  logic [WIDTH-1:0]        wd1;
  logic                    sb_set;
  logic [ADDR_W-1:0]       sb_addr;
  logic [(1<<ADDR_W)-1:0]  pend;

  modport master (
    output ra, we0, wa0, wd0, we1, wa1, wd1, sb_set, sb_addr,
    input  rd, rd_busy, pend
  );

  modport slave (
    input  ra, we0, wa0, wd0, we1, wa1, wd1, sb_set, sb_addr,
    output rd, rd_busy, pend
  );
endinterface

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with dual write, bypass and pending-write scoreboard
module register_file_mp #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  register_file_mp_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_nxt;
  logic             wr0_ok;
  logic             wr1_ok;

  assign wr0_ok = bus.we0 && !(ZERO_REG != 0 && bus.wa0 == '0);
  assign wr1_ok = bus.we1 && !(ZERO_REG != 0 && bus.wa1 == '0);

  // Clear for retiring writes first, then set, so a newly issued producer wins.
  always_comb begin
    pend_nxt = pend_q;
    if (bus.we0) pend_nxt[bus.wa0] = 1'b0;
    if (bus.we1) pend_nxt[bus.wa1] = 1'b0;
    if (bus.sb_set) pend_nxt[bus.sb_addr] = 1'b1;
    if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < DEPTH; n++) regs[n] <= '0;
      pend_q <= '0;
    end else begin
      if (wr0_ok) regs[bus.wa0] <= bus.wd0;
      // Port 1 is issued last so it overrides port 0 on an address collision.
      if (wr1_ok) regs[bus.wa1] <= bus.wd1;
      pend_q <= pend_nxt;
    end
  end

  assign bus.pend = pend_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit0;
    logic              hit1;
    logic              is_zero;
    logic [WIDTH-1:0]  val;

    assign a       = bus.ra[i*ADDR_W +: ADDR_W];
    assign hit0    = (BYPASS != 0) && bus.we0 && (bus.wa0 == a);
    assign hit1    = (BYPASS != 0) && bus.we1 && (bus.wa1 == a);
    assign is_zero = (ZERO_REG != 0) && (a == '0);

    always_comb begin
      val = regs[a];
      if (hit1) val = bus.wd1;
      else if (hit0) val = bus.wd0;
      if (is_zero) val = '0;
    end

    assign bus.rd[i*WIDTH +: WIDTH] = val;
    assign bus.rd_busy[i]           = pend_q[a] && !(hit0 || hit1) && !is_zero;
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - bench for register_file_mp with BYPASS=1 and BYPASS=0 instances
module tb_register_file_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  register_file_mp_if #(.WIDTH(32), .ADDR_W(5), .NREAD(2)) if1 ();
  register_file_mp_if #(.WIDTH(32), .ADDR_W(5), .NREAD(2)) if0 ();

  register_file_mp #(.WIDTH(32), .ADDR_W(5), .NREAD(2), .BYPASS(1), .ZERO_REG(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );
  register_file_mp #(.WIDTH(32), .ADDR_W(5), .NREAD(2), .BYPASS(0), .ZERO_REG(1)) u_b0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave)
  );

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        chk;
    logic [31:0] e1r0, e1r1;
    logic [1:0]  e1b;
    logic [31:0] e0r0, e0r1;
    logic [1:0]  e0b;
  } vec_t;

  typedef struct {
    logic [63:0] rd;
    logic [1:0]  busy;
    logic [31:0] pend;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  exp_t exp_q [$];
  vec_t tbl [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic sbs, input logic [4:0] sba,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] e1r0, input logic [31:0] e1r1, input logic [1:0] e1b,
                              input logic [31:0] e0r0, input logic [31:0] e0r1, input logic [1:0] e0b);
    vec_t v;
    v.s = '{we0, wa0, wd0, we1, wa1, wd1, sbs, sba, ra0, ra1};
    v.chk = 1'b1;
    v.e1r0 = e1r0; v.e1r1 = e1r1; v.e1b = e1b;
    v.e0r0 = e0r0; v.e0r1 = e0r1; v.e0b = e0b;
    return v;
  endfunction

  function automatic logic [31:0] m_read(input int byp, input logic [4:0] a, input stim_t s);
    logic [31:0] v;
    v = m_regs[a];
    if (byp != 0 && s.we1 && s.wa1 == a) v = s.wd1;
    else if (byp != 0 && s.we0 && s.wa0 == a) v = s.wd0;
    if (a == 5'd0) v = '0;
    return v;
  endfunction

  function automatic logic m_busy(input int byp, input logic [4:0] a, input stim_t s);
    logic wr;
    wr = (s.we0 && s.wa0 == a) || (s.we1 && s.wa1 == a);
    return m_pend[a] && !(byp != 0 && wr) && (a != 5'd0);
  endfunction

  function automatic exp_t m_exp(input int byp, input stim_t s);
    exp_t e;
    e.rd   = {m_read(byp, s.ra1, s), m_read(byp, s.ra0, s)};
    e.busy = {m_busy(byp, s.ra1, s), m_busy(byp, s.ra0, s)};
    e.pend = m_pend;
    return e;
  endfunction

  task automatic m_reset();
    for (int n = 0; n < 32; n++) m_regs[n] = '0;
    m_pend = '0;
  endtask

  task automatic m_update(input stim_t s);
    if (s.we0 && s.wa0 != 5'd0) m_regs[s.wa0] = s.wd0;
    if (s.we1 && s.wa1 != 5'd0) m_regs[s.wa1] = s.wd1;
    if (s.we0) m_pend[s.wa0] = 1'b0;
    if (s.we1) m_pend[s.wa1] = 1'b0;
    if (s.sb_set) m_pend[s.sb_addr] = 1'b1;
    m_pend[0] = 1'b0;
  endtask

  task automatic drive(input stim_t s);
    if1.we0 = s.we0; if1.wa0 = s.wa0; if1.wd0 = s.wd0;
    if1.we1 = s.we1; if1.wa1 = s.wa1; if1.wd1 = s.wd1;
    if1.sb_set = s.sb_set; if1.sb_addr = s.sb_addr; if1.ra = {s.ra1, s.ra0};
    if0.we0 = s.we0; if0.wa0 = s.wa0; if0.wd0 = s.wd0;
    if0.we1 = s.we1; if0.wa1 = s.wa1; if0.wd1 = s.wd1;
    if0.sb_set = s.sb_set; if0.sb_addr = s.sb_addr; if0.ra = {s.ra1, s.ra0};
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic run(input vec_t v);
    exp_t e;
    drive(v.s);
    exp_q.push_back(m_exp(1, v.s));
    exp_q.push_back(m_exp(0, v.s));
    #2;
    e = exp_q.pop_front();
    chk("b1_rd", if1.rd, e.rd);
    chk("b1_busy", {62'd0, if1.rd_busy}, {62'd0, e.busy});
    chk("b1_pend", {32'd0, if1.pend}, {32'd0, e.pend});
    e = exp_q.pop_front();
    chk("b0_rd", if0.rd, e.rd);
    chk("b0_busy", {62'd0, if0.rd_busy}, {62'd0, e.busy});
    chk("b0_pend", {32'd0, if0.pend}, {32'd0, e.pend});
    if (v.chk) begin
      chk("tbl_b1_rd", if1.rd, {v.e1r1, v.e1r0});
      chk("tbl_b1_busy", {62'd0, if1.rd_busy}, {62'd0, v.e1b});
      chk("tbl_b0_rd", if0.rd, {v.e0r1, v.e0r0});
      chk("tbl_b0_busy", {62'd0, if0.rd_busy}, {62'd0, v.e0b});
    end
    @(posedge clk);
    if (rst_n) m_update(v.s);
    @(negedge clk);
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_b1_rd"}, if1.rd, 64'd0);
    chk({tag, "_b0_rd"}, if0.rd, 64'd0);
    chk({tag, "_b1_busy"}, {62'd0, if1.rd_busy}, 64'd0);
    chk({tag, "_b1_pend"}, {32'd0, if1.pend}, 64'd0);
    chk({tag, "_b0_pend"}, {32'd0, if0.pend}, 64'd0);
  endtask

  initial begin
    stim_t idle;
    stim_t s;
    vec_t  rv;
    idle = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0};
    m_reset();

    //     we0 wa0 wd0           we1 wa1 wd1           sb  sba ra0 ra1  b1:r0 r1 busy             b0:r0 r1 busy
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,  0,  5, 0, 0, 2'b00,                   0, 0, 2'b00));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 31,  5, 0, 0, 2'b00,                   0, 0, 2'b00));
    tbl.push_back(mk(1, 7, 32'hAAAA0000, 1, 7, 32'h5555FFFF, 0, 0,  7,  7, 32'h5555FFFF, 32'h5555FFFF, 2'b00, 0, 0, 2'b00));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,  7,  7, 32'h5555FFFF, 32'h5555FFFF, 2'b00, 32'h5555FFFF, 32'h5555FFFF, 2'b00));
    tbl.push_back(mk(1, 0, 32'hDEADBEEF, 0, 0, 0,            1, 0,  0,  7, 0, 32'h5555FFFF, 2'b00,        0, 32'h5555FFFF, 2'b00));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,  0,  0, 0, 0, 2'b00,                   0, 0, 2'b00));
    tbl.push_back(mk(1, 3, 32'h12345678, 0, 0, 0,            0, 0,  3,  3, 32'h12345678, 32'h12345678, 2'b00, 0, 0, 2'b00));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,  3,  3, 32'h12345678, 32'h12345678, 2'b00, 32'h12345678, 32'h12345678, 2'b00));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,            1, 9,  9,  9, 0, 0, 2'b00,                   0, 0, 2'b00));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,  9,  9, 0, 0, 2'b11,                   0, 0, 2'b11));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,  9,  3, 0, 32'h12345678, 2'b01,        0, 32'h12345678, 2'b01));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,  9,  9, 0, 0, 2'b11,                   0, 0, 2'b11));
    tbl.push_back(mk(1, 9, 32'h00000099, 0, 0, 0,            0, 0,  9,  9, 32'h99, 32'h99, 2'b00,         0, 0, 2'b11));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,  9,  9, 32'h99, 32'h99, 2'b00,         32'h99, 32'h99, 2'b00));
    tbl.push_back(mk(0, 0, 0,            1, 12, 32'hC0FFEE12, 1, 12, 12, 12, 32'hC0FFEE12, 32'hC0FFEE12, 2'b00, 0, 0, 2'b00));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 12, 12, 32'hC0FFEE12, 32'hC0FFEE12, 2'b11, 32'hC0FFEE12, 32'hC0FFEE12, 2'b11));

    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk_clear("in_reset");
    rst_n = 1'b1;

    foreach (tbl[k]) run(tbl[k]);

    // Asynchronous reset between edges clears state immediately.
    s = idle; s.ra0 = 5'd12; s.ra1 = 5'd12;
    drive(s);
    #2;
    chk("pre_rst_rd12", if1.rd, {32'hC0FFEE12, 32'hC0FFEE12});
    rst_n = 1'b0;
    m_reset();
    #1;
    chk_clear("mid_rst");

    // Writes and sb_set on an edge held in reset have no effect.
    s = idle; s.we0 = 1'b1; s.wa0 = 5'd5; s.wd0 = 32'h55; s.sb_set = 1'b1; s.sb_addr = 5'd5;
    s.ra0 = 5'd5; s.ra1 = 5'd12;
    drive(s);
    @(posedge clk);
    @(negedge clk);
    s = idle; s.ra0 = 5'd5; s.ra1 = 5'd12;
    drive(s);
    rst_n = 1'b1;
    #2;
    chk_clear("rst_edge");

    for (int c = 0; c < 300; c++) begin
      rv.chk = 1'b0;
      rv.e1r0 = '0; rv.e1r1 = '0; rv.e1b = '0; rv.e0r0 = '0; rv.e0r1 = '0; rv.e0b = '0;
      rv.s.we0 = 1'($urandom_range(0, 1));
      rv.s.wa0 = 5'($urandom_range(0, 15));
      rv.s.wd0 = $urandom;
      rv.s.we1 = 1'($urandom_range(0, 1));
      rv.s.wa1 = 5'($urandom_range(0, 15));
      rv.s.wd1 = $urandom;
      rv.s.sb_set = 1'($urandom_range(0, 1));
      rv.s.sb_addr = 5'($urandom_range(0, 15));
      rv.s.ra0 = 5'($urandom_range(0, 15));
      rv.s.ra1 = (c % 4 == 0) ? rv.s.wa1 : 5'($urandom_range(0, 31));
      run(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
